// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: conditions the pad clock and data, deframes 11-bit frames, and
// strips E0/F0 prefixes so that only make codes are reported, each with an extended tag.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYC    = 100000,
    parameter bit SUPPRESS_BREAK = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       flag,
    output logic       extended,
    output logic       frame_err
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic          ps2_clk_p0, ps2_clk_p1;
    logic          ps2_data_p0, ps2_data_p1;
    logic          clk_f;
    logic [FW-1:0] fcnt;
    logic          flip;
    logic          sample;
    logic [1:0]    state;
    logic [2:0]    bitcnt;
    logic [TW-1:0] tcnt;
    logic          ext_pend, brk_pend;
    logic [7:0]    shreg;
    logic          par_bit;

    // Data plus parity must carry an odd number of ones.
    function automatic logic odd_ones(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    // Stage p0/p1: two-flop synchronizers, idle-high after reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_data_p0 <= ps2_data;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    // Filtered clock flips on the FILTER_LEN-th consecutive differing sample; a flip from 1 is a sample event
    assign flip   = (ps2_clk_p1 != clk_f) && (fcnt == FW'(FILTER_LEN - 1));
    assign sample = flip && clk_f;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_f <= 1'b1;
            fcnt  <= '0;
        end else if (ps2_clk_p1 == clk_f) begin
            fcnt  <= '0;
        end else if (flip) begin
            clk_f <= ~clk_f;
            fcnt  <= '0;
        end else begin
            fcnt  <= fcnt + FW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (sample && state == DATA)
            shreg <= {ps2_data_p1, shreg[7:1]};
        if (sample && state == PARITY)
            par_bit <= ps2_data_p1;
    end

    // Frame FSM, timeout, and prefix handling; outputs settle the cycle after the stop-bit event
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bitcnt    <= '0;
            tcnt      <= '0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            scancode  <= '0;
            extended  <= 1'b0;
            flag      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            flag      <= 1'b0;
            frame_err <= 1'b0;

            if (sample || state == IDLE)
                tcnt <= '0;
            else
                tcnt <= tcnt + TW'(1);

            if (sample) begin
                case (state)
                    IDLE: begin
                        if (!ps2_data_p1) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: state <= STOP;
                    default: begin
                        state <= IDLE;
                        if (ps2_data_p1 && odd_ones(shreg, par_bit)) begin
                            if (shreg == 8'hE0) begin
                                ext_pend <= 1'b1;
                            end else if (shreg == 8'hF0) begin
                                brk_pend <= 1'b1;
                            end else begin
                                ext_pend <= 1'b0;
                                brk_pend <= 1'b0;
                                if (!(brk_pend && SUPPRESS_BREAK)) begin
                                    scancode <= shreg;
                                    extended <= ext_pend;
                                    flag     <= 1'b1;
                                end
                            end
                        end else begin
                            frame_err <= 1'b1;
                            ext_pend  <= 1'b0;
                            brk_pend  <= 1'b0;
                        end
                    end
                endcase
            end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYC - 1)) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: two instances (break suppression on/off) share one PS/2 stimulus.
module tb_ps2_scancode_rx;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 500;
    localparam int HALF        = 40;   // half PS/2 clock period in system clocks

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode0, scancode1;
    logic       flag0, flag1, ext0, ext1, err0, err1;

    int nchecks = 0;
    int nerrors = 0;
    int nflag0 = 0, nflag1 = 0, nerr0 = 0, nboth = 0;

    ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .SUPPRESS_BREAK(1'b1)) dut0 (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(scancode0), .flag(flag0), .extended(ext0), .frame_err(err0));

    ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .SUPPRESS_BREAK(1'b0)) dut1 (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scancode(scancode1), .flag(flag1), .extended(ext1), .frame_err(err1));

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if (flag0) nflag0++;
            if (flag1) nflag1++;
            if (err0) nerr0++;
            if (flag0 && err0) nboth++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clock);
        ps2_data = b;
        idle(HALF);
        ps2_clk = 1'b0;
        idle(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        idle(60);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(b[i]);
        ps2_data = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f0, f1, e0;
        idle(5);
        check("rst_scancode", {24'd0, scancode0}, 32'h0);
        check("rst_flag", {31'd0, flag0}, 32'h0);
        check("rst_extended", {31'd0, ext0}, 32'h0);
        check("rst_frame_err", {31'd0, err0}, 32'h0);
        reset = 1'b0;
        idle(20);

        f0 = nflag0; e0 = nerr0;
        send_frame(8'h16, 1'b0);
        check("m16_flags", nflag0 - f0, 1);
        check("m16_code", {24'd0, scancode0}, 32'h16);
        check("m16_ext", {31'd0, ext0}, 32'h0);
        check("m16_err", nerr0 - e0, 0);

        f0 = nflag0;
        send_frame(8'hE0, 1'b0);
        check("e0_noflag", nflag0 - f0, 0);
        send_frame(8'h75, 1'b0);
        check("e075_flags", nflag0 - f0, 1);
        check("e075_code", {24'd0, scancode0}, 32'h75);
        check("e075_ext", {31'd0, ext0}, 32'h1);
        send_frame(8'h72, 1'b0);
        check("m72_code", {24'd0, scancode0}, 32'h72);
        check("m72_ext", {31'd0, ext0}, 32'h0);

        f0 = nflag0; f1 = nflag1;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h16, 1'b0);
        check("brk_sup_flags", nflag0 - f0, 0);
        check("brk_sup_code", {24'd0, scancode0}, 32'h72);
        check("brk_nosup_flags", nflag1 - f1, 1);
        check("brk_nosup_code", {24'd0, scancode1}, 32'h16);

        f0 = nflag0; e0 = nerr0;
        send_frame(8'h1E, 1'b1);
        check("par_err", nerr0 - e0, 1);
        check("par_noflag", nflag0 - f0, 0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1E, 1'b1);
        send_frame(8'h74, 1'b0);
        check("par2_err", nerr0 - e0, 2);
        check("par2_flags", nflag0 - f0, 1);
        check("par2_code", {24'd0, scancode0}, 32'h74);
        check("par2_ext", {31'd0, ext0}, 32'h0);

        f0 = nflag0; e0 = nerr0;
        send_partial(8'h2D, 4);
        idle(TIMEOUT_CYC + 10);
        check("tmo_err", nerr0 - e0, 1);
        check("tmo_noflag", nflag0 - f0, 0);
        send_frame(8'h2D, 1'b0);
        check("tmo_next_flags", nflag0 - f0, 1);
        check("tmo_next_code", {24'd0, scancode0}, 32'h2D);
        check("tmo_next_err", nerr0 - e0, 1);

        f0 = nflag0; e0 = nerr0;
        @(negedge clock);
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        idle(FILTER_LEN - 2);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        idle(TIMEOUT_CYC + 10);
        check("glitch_noflag", nflag0 - f0, 0);
        check("glitch_noerr", nerr0 - e0, 0);

        send_partial(8'h25, 3);
        @(negedge clock);
        reset = 1'b1;
        idle(3);
        check("mid_rst_scancode", {24'd0, scancode0}, 32'h0);
        check("mid_rst_flag", {31'd0, flag0}, 32'h0);
        check("mid_rst_extended", {31'd0, ext0}, 32'h0);
        check("mid_rst_frame_err", {31'd0, err0}, 32'h0);
        reset = 1'b0;
        idle(20);
        f0 = nflag0; e0 = nerr0;
        send_frame(8'h25, 1'b0);
        check("post_rst_flags", nflag0 - f0, 1);
        check("post_rst_code", {24'd0, scancode0}, 32'h25);
        check("post_rst_err", nerr0 - e0, 0);

        check("flag_err_overlap", nboth, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
